// File: rtl/router_pkt_tx_if.sv
// Host and router signals of the router packet source, grouped as one bundle.
//  slave  : the packet source (router_pkt_tx) side
//  master : the host + router side (drives requests, payload, busy/err)
// Signals:
//  tx_req/tx_dest/tx_len -> tx_ack/tx_rej   packet request handshake
//  wr_data/wr_valid      -> wr_ready        payload byte write
//  busy/err              -> pkt_valid/data_in  router port
//  tx_done/tx_err/tx_idle                   packet status
interface router_pkt_tx_if;
  logic       tx_req;
  logic [1:0] tx_dest;
  logic [5:0] tx_len;
  logic       tx_ack;
  logic       tx_rej;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       tx_done;
  logic       tx_err;
  logic       tx_idle;

  modport slave (
    input  tx_req, tx_dest, tx_len, wr_data, wr_valid, busy, err,
    output tx_ack, tx_rej, wr_ready, pkt_valid, data_in, tx_done, tx_err, tx_idle
  );

  modport master (
    output tx_req, tx_dest, tx_len, wr_data, wr_valid, busy, err,
    input  tx_ack, tx_rej, wr_ready, pkt_valid, data_in, tx_done, tx_err, tx_idle
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port. Buffers a whole payload from
// the host, then sends header {len,dest}, payload bytes (pkt_valid=1) and the
// XOR parity byte (pkt_valid=0), advancing only on edges where busy=0.
// Afterwards the router err flag is sampled for ERR_WAIT cycles and reported.
// Ports:
//  clock  rising-edge clock
//  reset  asynchronous active-high reset
//  bus    router_pkt_tx_if.slave: request, payload write, router and status signals
module router_pkt_tx #(
  parameter int unsigned ERR_WAIT = 3,
  parameter int unsigned IFG      = 2
) (
  input logic            clock,
  input logic            reset,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FILL, HEADER, PAYLOAD, PARITY, STATUS} state_t;

  state_t     state, state_n;
  logic [1:0] dest_q, dest_n;
  logic [5:0] len_q, len_n;
  logic [5:0] wcnt, wcnt_n;
  logic [5:0] rcnt, rcnt_n;
  logic [7:0] par, par_n;
  logic [3:0] scnt, scnt_n;
  logic [3:0] ifg_cnt, ifg_n;
  logic       cap, cap_n;
  logic       ack_q, ack_n;
  logic       rej_q, rej_n;
  logic       done_q, done_n;
  logic       err_q, err_n;
  logic       wrr_q, wrr_n;
  logic       pv_q, pv_n;
  logic [7:0] din_q, din_n;
  logic [7:0] mem [0:63];
  logic       wr_en;
  logic       legal;

  assign wr_en = (state == FILL) && bus.wr_valid && wrr_q;
  assign legal = (bus.tx_len != '0) && (bus.tx_dest != 2'd3);

  // Payload buffer is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wcnt] <= bus.wr_data;
  end

  always_comb begin
    state_n = state;
    dest_n  = dest_q;
    len_n   = len_q;
    wcnt_n  = wcnt;
    rcnt_n  = rcnt;
    par_n   = par;
    scnt_n  = scnt;
    ifg_n   = ifg_cnt;
    cap_n   = cap;
    ack_n   = 1'b0;
    rej_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = err_q;
    wrr_n   = wrr_q;
    pv_n    = pv_q;
    din_n   = din_q;
    case (state)
      IDLE: begin
        // Requests are only looked at once the inter-frame gap has run out.
        if (ifg_cnt != '0) begin
          ifg_n = ifg_cnt - 4'd1;
        end else if (bus.tx_req) begin
          if (legal) begin
            dest_n  = bus.tx_dest;
            len_n   = bus.tx_len;
            ack_n   = 1'b1;
            err_n   = 1'b0;
            wcnt_n  = '0;
            par_n   = {bus.tx_len, bus.tx_dest};
            wrr_n   = 1'b1;
            state_n = FILL;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      FILL: begin
        if (wr_en) begin
          par_n  = par ^ bus.wr_data;
          wcnt_n = wcnt + 6'd1;
          if (wcnt == len_q - 6'd1) begin
            state_n = HEADER;
            pv_n    = 1'b1;
            din_n   = {len_q, dest_q};
            wrr_n   = 1'b0;
          end
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          state_n = PAYLOAD;
          rcnt_n  = '0;
          din_n   = mem[0];
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          if (rcnt == len_q - 6'd1) begin
            state_n = PARITY;
            pv_n    = 1'b0;
            din_n   = par;
          end else begin
            rcnt_n = rcnt + 6'd1;
            din_n  = mem[rcnt + 6'd1];
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          state_n = STATUS;
          din_n   = '0;
          scnt_n  = 4'(ERR_WAIT);
          cap_n   = 1'b0;
        end
      end
      STATUS: begin
        // Include this cycle's err in the reported status.
        cap_n = cap | bus.err;
        if (scnt <= 4'd1) begin
          done_n  = 1'b1;
          err_n   = cap | bus.err;
          state_n = IDLE;
          ifg_n   = 4'(IFG);
        end else begin
          scnt_n = scnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      wcnt    <= '0;
      rcnt    <= '0;
      par     <= '0;
      scnt    <= '0;
      ifg_cnt <= '0;
      cap     <= 1'b0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wrr_q   <= 1'b0;
      pv_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state   <= state_n;
      dest_q  <= dest_n;
      len_q   <= len_n;
      wcnt    <= wcnt_n;
      rcnt    <= rcnt_n;
      par     <= par_n;
      scnt    <= scnt_n;
      ifg_cnt <= ifg_n;
      cap     <= cap_n;
      ack_q   <= ack_n;
      rej_q   <= rej_n;
      done_q  <= done_n;
      err_q   <= err_n;
      wrr_q   <= wrr_n;
      pv_q    <= pv_n;
      din_q   <= din_n;
    end
  end

  assign bus.tx_ack    = ack_q;
  assign bus.tx_rej    = rej_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_err    = err_q;
  assign bus.wr_ready  = wrr_q;
  assign bus.pkt_valid = pv_q;
  assign bus.data_in   = din_q;
  assign bus.tx_idle   = (state == IDLE) && (ifg_cnt == '0);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a queue model of the bytes the
// router must receive plus status timing, checked every cycle on the falling
// edge, and literal expectations for the directed packets.
module tb_router_pkt_tx;
  localparam int unsigned EW   = 3;
  localparam int unsigned IFGP = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  router_pkt_tx_if bus();

  router_pkt_tx #(.ERR_WAIT(EW), .IFG(IFGP)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int ncmp  = 0;
  int nfail = 0;

  logic [8:0] q[$];      // {pkt_valid, data_in} still to be taken by the router
  logic [8:0] log_q[$];  // what the DUT actually handed over
  bit chk_en = 0, st_active = 0, cap_m = 0, done_exp = 0, err_hold = 0, idle_exp = 1;
  bit exp_ack = 0, exp_rej = 0, exp_wrr = 0, pkt_complete = 0, err_arm = 0;
  int sk = 0, busy_mode = 0, hold = 0, cnt22 = 0;
  logic [7:0] pl [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    ncmp++;
    nfail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Router/err driver: busy patterns and a single err pulse in the status window.
  always @(posedge clock) begin
    #1;
    case (busy_mode)
      1: bus.busy = 1'($urandom_range(0, 1));
      2: begin
        if (q.size() > 0 && q[0] == 9'h122 && hold > 0) begin
          bus.busy = 1'b1;
          hold--;
        end else bus.busy = 1'b0;
      end
      default: bus.busy = 1'b0;
    endcase
    bus.err = err_arm && st_active && (sk == 1);
  end

  // Compare process.
  always @(negedge clock) begin
    if (chk_en) begin
      done_exp = 0;
      if (st_active) begin
        sk++;
        if (sk <= int'(EW)) cap_m = cap_m | bus.err;
        if (sk == int'(EW) + 1) begin
          done_exp     = 1;
          err_hold     = cap_m;
          pkt_complete = 1;
        end
        if (sk >= int'(EW + IFGP) + 1) begin
          idle_exp  = 1;
          st_active = 0;
        end
      end
      if (q.size() > 0) begin
        chk("stream", 32'({bus.pkt_valid, bus.data_in}), 32'(q[0]));
        if (bus.pkt_valid && bus.data_in == 8'h22) cnt22++;
        if (!bus.busy) begin
          log_q.push_back({bus.pkt_valid, bus.data_in});
          if (q[0][8] == 1'b0) begin
            st_active = 1;
            sk        = 0;
            cap_m     = 0;
          end
          void'(q.pop_front());
        end
      end else begin
        chk("quiet", 32'({bus.pkt_valid, bus.data_in}), 32'd0);
      end
      chk("tx_done", 32'(bus.tx_done), 32'(done_exp));
      chk("tx_err", 32'(bus.tx_err), 32'(err_hold));
      chk("tx_idle", 32'(bus.tx_idle), 32'(idle_exp));
      chk("tx_ack", 32'(bus.tx_ack), 32'(exp_ack));
      chk("tx_rej", 32'(bus.tx_rej), 32'(exp_rej));
      chk("wr_ready", 32'(bus.wr_ready), 32'(exp_wrr));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_idle !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) timeout("wait_idle");
  endtask

  task automatic do_req(input logic [1:0] d, input logic [5:0] l, input bit ok);
    wait_idle();
    @(posedge clock); #1;
    bus.tx_req  = 1'b1;
    bus.tx_dest = d;
    bus.tx_len  = l;
    @(posedge clock); #1;
    bus.tx_req = 1'b0;
    if (ok) begin
      exp_ack      = 1;
      err_hold     = 0;
      idle_exp     = 0;
      exp_wrr      = 1;
      pkt_complete = 0;
      log_q.delete();
    end else begin
      exp_rej = 1;
    end
    @(posedge clock); #1;
    exp_ack = 0;
    exp_rej = 0;
  endtask

  task automatic fill(input logic [1:0] d, input int n, input bit gaps);
    logic [7:0] hdr;
    logic [7:0] p;
    hdr = {6'(n), d};
    p   = hdr;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.wr_valid = 1'b0;
          @(posedge clock); #1;
        end
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = pl[i];
      @(posedge clock); #1;
      p = p ^ pl[i];
    end
    bus.wr_valid = 1'b0;
    exp_wrr = 0;
    q.push_back({1'b1, hdr});
    for (int i = 0; i < n; i++) q.push_back({1'b1, pl[i]});
    q.push_back({1'b0, p});
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while (!pkt_complete && n < 3000);
    if (!pkt_complete) timeout("wait_done");
  endtask

  logic [8:0] e2 [5];
  int n_ifg;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_req = 0; bus.tx_dest = 0; bus.tx_len = 0;
    bus.wr_data = 0; bus.wr_valid = 0; bus.busy = 0; bus.err = 0;
    e2 = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_pv_data", 32'({bus.pkt_valid, bus.data_in}), 32'd0);
    chk("rst_status", 32'({bus.tx_ack, bus.tx_rej, bus.tx_done, bus.tx_err, bus.wr_ready, bus.tx_idle}),
        32'b000001);
    chk_en = 1;

    // T2: dest 1, len 3, no busy
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    do_req(2'd1, 6'd3, 1);
    fill(2'd1, 3, 0);
    wait_done();
    chk("t2_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < log_q.size()) chk("t2_byte", 32'(log_q[i]), 32'(e2[i]));
    chk("t2_err", 32'(bus.tx_err), 32'd0);

    // T3: busy held for 4 cycles while 22 is presented
    busy_mode = 2; hold = 4; cnt22 = 0;
    do_req(2'd1, 6'd3, 1);
    fill(2'd1, 3, 0);
    wait_done();
    chk("t3_hold22", 32'(cnt22), 32'd5);
    for (int i = 0; i < 5; i++) if (i < log_q.size()) chk("t3_byte", 32'(log_q[i]), 32'(e2[i]));
    busy_mode = 0;

    // T4: illegal requests
    do_req(2'd0, 6'd0, 0);
    do_req(2'd3, 6'd5, 0);

    // T5: err pulse during status
    pl[0] = 8'hAA; pl[1] = 8'h55;
    err_arm = 1;
    do_req(2'd0, 6'd2, 1);
    fill(2'd0, 2, 0);
    wait_done();
    err_arm = 0;
    chk("t5_err", 32'(bus.tx_err), 32'd1);

    // T6: 63-byte packet, random gaps and busy; IFG blocking
    for (int i = 0; i < 63; i++) pl[i] = 8'(i + 1);
    busy_mode = 1;
    do_req(2'd2, 6'd63, 1);
    chk("t5_err_clr", 32'(bus.tx_err), 32'd0);
    fill(2'd2, 63, 1);
    wait_done();
    n_ifg = 0;
    while (bus.tx_idle !== 1'b1 && n_ifg < 50) begin
      @(negedge clock);
      n_ifg++;
    end
    chk("t6_ifg", 32'(n_ifg), 32'd2);
    chk("t6_len", 32'(log_q.size()), 32'd65);
    if (log_q.size() == 65) begin
      chk("t6_hdr", 32'(log_q[0]), 32'h1FE);
      chk("t6_par", 32'(log_q[64]), 32'h0FE);
      for (int i = 1; i < 64; i++) chk("t6_byte", 32'(log_q[i]), 32'h100 + 32'(i));
    end
    busy_mode = 0;

    // T1: reset in the middle of the payload
    pl[0] = 8'h05; pl[1] = 8'h06; pl[2] = 8'h07; pl[3] = 8'h08;
    do_req(2'd1, 6'd4, 1);
    fill(2'd1, 4, 0);
    begin
      int n = 0;
      while (!(q.size() > 0 && q.size() <= 3) && n < 200) begin
        @(negedge clock); #1;
        n++;
      end
      if (n >= 200) timeout("t1_mid");
    end
    chk("t1_pv_before", 32'(bus.pkt_valid), 32'd1);
    chk_en = 0;
    #1 reset = 1'b1;
    #1;
    chk("t1_pv_data", 32'({bus.pkt_valid, bus.data_in}), 32'd0);
    chk("t1_status", 32'({bus.tx_ack, bus.tx_rej, bus.tx_done, bus.tx_err, bus.wr_ready, bus.tx_idle}),
        32'b000001);
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    st_active = 0; sk = 0; cap_m = 0; err_hold = 0; idle_exp = 1;
    exp_ack = 0; exp_rej = 0; exp_wrr = 0;
    chk_en = 1;

    // Recovery packet after the abandoned one
    pl[0] = 8'h5A;
    do_req(2'd2, 6'd1, 1);
    fill(2'd2, 1, 0);
    wait_done();
    chk("rec_len", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("rec_hdr", 32'(log_q[0]), 32'h106);
      chk("rec_pay", 32'(log_q[1]), 32'h15A);
      chk("rec_par", 32'(log_q[2]), 32'h05C);
    end

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
